// File: rtl/dram_sync_fifo_if.sv
// Handshake bundle for dram_sync_fifo: write side, read side, control and status.
// Valid/ready semantics:
//   - A write is accepted on a rising edge where WR_EN=1 and WR_READY=1.
//   - A read is accepted on a rising edge where RD_EN=1 and RD_VALID=1.
//   - WR_READY and RD_VALID depend only on registered occupancy.
//   - RD_DATA is the head word while RD_VALID=1.
interface dram_sync_fifo_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4
);
    logic              FLUSH;
    logic [DATA_W-1:0] WR_DATA;
    logic              WR_EN;
    logic              WR_READY;
    logic              RD_EN;
    logic              RD_VALID;
    logic [DATA_W-1:0] RD_DATA;
    logic [ADDR_W:0]   LEVEL;
    logic              ALMOST_FULL;
    logic              ALMOST_EMPTY;
    logic              OVERFLOW;
    logic              UNDERFLOW;
    logic              CLR_FLAGS;

    // The producer/consumer side drives requests and observes status.
    modport master (
        output FLUSH, WR_DATA, WR_EN, RD_EN, CLR_FLAGS,
        input  WR_READY, RD_VALID, RD_DATA, LEVEL,
        input  ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW
    );

    // The FIFO side receives requests and drives status.
    modport slave (
        input  FLUSH, WR_DATA, WR_EN, RD_EN, CLR_FLAGS,
        output WR_READY, RD_VALID, RD_DATA, LEVEL,
        output ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/dram_sync_fifo.sv
// Single-clock first-word-fall-through FIFO on distributed dual-port RAM.
// Pointers wrap modulo DEPTH; a separate occupancy counter gives full/empty.
module dram_sync_fifo #(
    parameter int DATA_W     = 20,
    parameter int ADDR_W     = 4,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    dram_sync_fifo_if.slave   fifo
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W + 1)'(AEMPTY_LVL);

    // Thresholds outside the occupancy range would make the status flags meaningless.
    if (AFULL_LVL > DEPTH || AEMPTY_LVL >= DEPTH || AFULL_LVL < 0 || AEMPTY_LVL < 0) begin : g_param_chk
        $error("dram_sync_fifo: AFULL_LVL must be <= DEPTH and AEMPTY_LVL < DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              empty;
    logic              live;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_q;
    logic              udf_q;

    // Accept decode: reset and flush suppress every operation in their cycle.
    always_comb begin
        full   = (level == DEPTH_C);
        empty  = (level == '0);
        live   = RST_N & ~fifo.FLUSH;
        wr_acc = live & fifo.WR_EN & ~full;
        rd_acc = live & fifo.RD_EN & ~empty;
    end

    // Storage write port; contents are never reset so the RAM maps to LUTs.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= fifo.WR_DATA;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge CLK) begin
        if (!live) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags; a new offending request beats a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (!live) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (fifo.WR_EN && full)    ovf_q <= 1'b1;
            else if (fifo.CLR_FLAGS)   ovf_q <= 1'b0;
            if (fifo.RD_EN && empty)   udf_q <= 1'b1;
            else if (fifo.CLR_FLAGS)   udf_q <= 1'b0;
        end
    end

    // Status decode from registered occupancy only; asynchronous read of the head word.
    always_comb begin
        fifo.WR_READY     = ~full;
        fifo.RD_VALID     = ~empty;
        fifo.RD_DATA      = mem[rd_ptr];
        fifo.LEVEL        = level;
        fifo.ALMOST_FULL  = (level >= AFULL_C);
        fifo.ALMOST_EMPTY = (level <= AEMPTY_C);
        fifo.OVERFLOW     = ovf_q;
        fifo.UNDERFLOW    = udf_q;
    end
endmodule
